// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready word stream from the dump engine to a debug
// consumer. master drives data/valid/last, slave drives ready.
interface regfile_dump_if #(
  parameter int REGWIDTH = 16
);
  logic [REGWIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: on start, walks regfile indices 0..NUMREGS-1 through the
// combinational read port and streams each captured word on out_if.
// Ports: clk, rst (sync, active high), start, rf_rd_sel/rf_rd_data,
// out_if (stream master), busy, done, err (start while busy).
module regfile_dump #(
  parameter int REGWIDTH = 16,
  parameter int NUMREGS  = 8,
  parameter int SELWIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [SELWIDTH-1:0] rf_rd_sel,
  input  logic [REGWIDTH-1:0] rf_rd_data,
  regfile_dump_if.master      out_if,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [SELWIDTH-1:0] r_idx;
  logic [REGWIDTH-1:0] r_data;
  logic                r_last;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_at_end;

  assign w_at_end = (r_idx == SELWIDTH'(NUMREGS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // snapshot taken here; later regfile writes cannot touch it
          r_data  <= rf_rd_data;
          r_last  <= w_at_end;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (out_if.out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + SELWIDTH'(1);
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_rd_sel        = r_idx;
  assign out_if.out_data  = r_data;
  assign out_if.out_valid = r_valid;
  assign out_if.out_last  = r_last;
  assign busy             = r_busy;
  assign done             = r_done;
  // flags the offending start in the same cycle it is presented
  assign err              = start & r_busy;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: table vectors, hand-written corner sequences and
// randomized dumps checked against a queue-based stream model.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  sel;
  logic [15:0] rd;
  logic        busy, done, err;
  logic [15:0] rf [8];

  logic        start1 = 1'b0;
  logic        sel1;
  logic [15:0] rd1;
  logic        busy1, done1, err1;
  logic [15:0] rf1;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_dump_if #(.REGWIDTH(16)) sif ();
  regfile_dump_if #(.REGWIDTH(16)) sif1 ();

  assign rd  = rf[sel];
  assign rd1 = (sel1 == 1'b0) ? rf1 : 16'hDEAD;

  regfile_dump #(.REGWIDTH(16), .NUMREGS(8), .SELWIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rf_rd_sel(sel), .rf_rd_data(rd),
    .out_if(sif),
    .busy(busy), .done(done), .err(err)
  );

  regfile_dump #(.REGWIDTH(16), .NUMREGS(1), .SELWIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .rf_rd_sel(sel1), .rf_rd_data(rd1),
    .out_if(sif1),
    .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_last;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_err;
    logic        chk_sel;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf();
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
  endtask

  // run until done is seen (bounded), then one cycle to return to idle
  task automatic finish_dump(input string nm);
    bit seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
      nxt();
    end
    chk({nm, "_done_seen"}, 32'(seen), 1);
  endtask

  task automatic rand_dump(input int stall_pct);
    logic [15:0] q[$];
    bit          pend_done;
    bit          got_done;
    bit          prev_hold;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'($urandom);
      q.push_back(rf[i]);
    end
    start = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    chk("rnd_err_idle", 32'(err), 0);
    chk("rnd_busy_idle", 32'(busy), 0);
    nxt();
    pend_done = 0;
    got_done = 0;
    prev_hold = 0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      sif.out_ready = ($urandom_range(99) >= stall_pct);
      start = ($urandom_range(9) == 0);
      @(negedge clk);
      chk("rnd_busy", 32'(busy), 1);
      chk("rnd_err", 32'(err), 32'(start));
      chk("rnd_done", 32'(done), 32'(pend_done));
      if (pend_done) begin
        got_done = 1;
      end else begin
        if (prev_hold) chk("rnd_hold_valid", 32'(sif.out_valid), 1);
        if (sif.out_valid) begin
          if (q.size() == 0) begin
            chk("rnd_extra_word", 1, 0);
          end else begin
            chk("rnd_data", 32'(sif.out_data), 32'(q[0]));
            chk("rnd_last", 32'(sif.out_last), 32'(q.size() == 1));
            if (sif.out_ready) begin
              void'(q.pop_front());
              if (q.size() == 0) pend_done = 1;
            end
          end
        end
        prev_hold = sif.out_valid && !sif.out_ready;
      end
      nxt();
    end
    start = 1'b0;
    chk("rnd_finished", 32'(got_done), 1);
    chk("rnd_left", 32'(q.size()), 0);
    @(negedge clk);
    chk("rnd_idle", 32'(busy), 0);
    nxt();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int words;
    int cyc;
    sif.out_ready  = 1'b1;
    sif1.out_ready = 1'b1;
    rf1 = 16'h5A3C;
    load_rf();
    nxt();
    nxt();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(sif.out_valid), 0);
    chk("rst_data", 32'(sif.out_data), 0);
    chk("rst_last", 32'(sif.out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sel", 32'(sel), 0);
    nxt();

    // full dump at full rate; second pass re-pulses start at cycle 5
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 19; c++) begin
        tbl[c].start     = (c == 0) || (p == 1 && c == 5);
        tbl[c].ready     = 1'b1;
        tbl[c].exp_valid = (c >= 2 && c <= 16 && c % 2 == 0);
        tbl[c].exp_data  = 16'h1000 + 16'(c / 2 - 1);
        tbl[c].exp_last  = (c == 16);
        tbl[c].exp_busy  = (c >= 1 && c <= 17);
        tbl[c].exp_done  = (c == 17);
        tbl[c].exp_err   = (p == 1 && c == 5);
        tbl[c].chk_sel   = (c >= 1 && c <= 16);
        tbl[c].exp_sel   = 3'((c - 1) / 2);
      end
      for (int c = 0; c < 19; c++) begin
        start = tbl[c].start;
        sif.out_ready = tbl[c].ready;
        @(negedge clk);
        chk("tbl_valid", 32'(sif.out_valid), 32'(tbl[c].exp_valid));
        if (tbl[c].exp_valid)
          chk("tbl_data", 32'(sif.out_data), 32'(tbl[c].exp_data));
        chk("tbl_last", 32'(sif.out_last), 32'(tbl[c].exp_last));
        chk("tbl_busy", 32'(busy), 32'(tbl[c].exp_busy));
        chk("tbl_done", 32'(done), 32'(tbl[c].exp_done));
        chk("tbl_err", 32'(err), 32'(tbl[c].exp_err));
        if (tbl[c].chk_sel)
          chk("tbl_sel", 32'(sel), 32'(tbl[c].exp_sel));
        nxt();
      end
      start = 1'b0;
    end

    // backpressure: word 0x1002 stalled for 5 cycles (cycles 6..10)
    words = 0;
    start = 1'b1;
    for (cyc = 0; cyc < 40 && words < 9; cyc++) begin
      sif.out_ready = !(cyc >= 6 && cyc <= 10);
      @(negedge clk);
      if (cyc >= 6 && cyc <= 10) begin
        chk("bp_hold_valid", 32'(sif.out_valid), 1);
        chk("bp_hold_data", 32'(sif.out_data), 32'h1002);
      end
      if (sif.out_valid && sif.out_ready) begin
        chk("bp_word", 32'(sif.out_data), 32'(16'h1000 + 16'(words)));
        words++;
      end
      if (done) begin
        chk("bp_done_cyc", 32'(cyc), 22);
        words = words + 100;
      end
      nxt();
      start = 1'b0;
    end
    chk("bp_count", 32'(words), 108);
    sif.out_ready = 1'b1;
    nxt();

    // snapshot: write after the capture edge keeps the old value
    start = 1'b1;
    for (cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 6) rf[2] = 16'hBEEF;
      @(negedge clk);
      if (cyc == 6) chk("snap_late", 32'(sif.out_data), 32'h1002);
      nxt();
      start = 1'b0;
    end
    finish_dump("snap_late");
    load_rf();

    // snapshot: write before the READ cycle is picked up
    start = 1'b1;
    for (cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 4) rf[2] = 16'hBEEF;
      @(negedge clk);
      if (cyc == 6) chk("snap_early", 32'(sif.out_data), 32'hBEEF);
      nxt();
      start = 1'b0;
    end
    finish_dump("snap_early");
    load_rf();

    // reset mid-dump at cycle 7
    start = 1'b1;
    for (cyc = 0; cyc < 7; cyc++) begin
      nxt();
      start = 1'b0;
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(sif.out_valid), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_data", 32'(sif.out_data), 0);
    nxt();
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    @(negedge clk);
    chk("post_rst_valid", 32'(sif.out_valid), 1);
    chk("post_rst_first", 32'(sif.out_data), 32'h1000);
    nxt();
    finish_dump("post_rst");

    // single-register instance
    start1 = 1'b1;
    nxt();
    start1 = 1'b0;
    @(negedge clk);
    chk("n1_sel", 32'(sel1), 0);
    chk("n1_busy1", 32'(busy1), 1);
    nxt();
    @(negedge clk);
    chk("n1_valid", 32'(sif1.out_valid), 1);
    chk("n1_last", 32'(sif1.out_last), 1);
    chk("n1_data", 32'(sif1.out_data), 32'h5A3C);
    nxt();
    @(negedge clk);
    chk("n1_done", 32'(done1), 1);
    chk("n1_valid_off", 32'(sif1.out_valid), 0);
    nxt();
    @(negedge clk);
    chk("n1_idle", 32'(busy1), 0);
    chk("n1_done_off", 32'(done1), 0);
    nxt();

    // randomized dumps with varying backpressure
    for (int k = 0; k < 20; k++) rand_dump(k * 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
